// File: rtl/aes_key_pkg.sv
// Shared types and constants for the AES-128 key scheduler.
package aes_key_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SUB   = 2'd1,
    MIX   = 2'd2,
    READY = 2'd3
  } state_e;

  // Round keys held in the store: the cipher key plus one per round.
  localparam int NUM_RK = 11;

  // Round constant word; only the top byte is ever non-zero.
  function automatic logic [31:0] rcon(input logic [3:0] rnd);
    logic [7:0] rc;
    case (rnd)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return {rc, 24'h0};
  endfunction

endpackage

// File: rtl/aes_key_scheduler_if.sv
// Key-load and round-key read bus between the cipher core and the scheduler.
interface aes_key_scheduler_if #(parameter int KEY_W = 128);
  logic             load;
  logic [KEY_W-1:0] key;
  logic             busy;
  logic             keys_valid;
  logic             rk_req;
  logic [3:0]       rk_idx;
  logic             rk_ack;
  logic             rk_err;
  logic [KEY_W-1:0] rk_data;

  modport master (
    output load, key, rk_req, rk_idx,
    input  busy, keys_valid, rk_ack, rk_err, rk_data
  );

  modport slave (
    input  load, key, rk_req, rk_idx,
    output busy, keys_valid, rk_ack, rk_err, rk_data
  );
endinterface

// File: rtl/aes_key_scheduler_key_round_step.sv
// One AES-128 key expansion round: combines the previous round key with the
// substituted/rotated last word and the round constant.
module key_round_step (
  input  logic [127:0] prev_key_i,
  input  logic [31:0]  sub_word_i,
  input  logic [31:0]  rcon_i,
  output logic [127:0] next_key_o
);

  logic [31:0] t, n0, n1, n2, n3;

  assign t  = sub_word_i ^ rcon_i;
  assign n0 = prev_key_i[127:96] ^ t;
  assign n1 = prev_key_i[95:64]  ^ n0;
  assign n2 = prev_key_i[63:32]  ^ n1;
  assign n3 = prev_key_i[31:0]   ^ n2;
  assign next_key_o = {n0, n1, n2, n3};

endmodule

// File: rtl/sbox_sync.sv
// AES S-box with a registered output (one cycle latency).
// The table is derived from GF(2^8) inversion plus the affine map so there is
// no hand-typed 256-entry constant to get wrong.
module sbox_sync (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] a_i,
  output logic [7:0] q_o
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p  = 8'h00;
    aa = a;
    bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
      bb = bb >> 1;
    end
    return p;
  endfunction

  // x^254 is the multiplicative inverse in GF(2^8) and maps 0 to 0.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] p, r;
    p = x;
    r = 8'h01;
    for (int i = 0; i < 7; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^
           {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  // Registered lookup.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) q_o <= 8'h00;
    else          q_o <= sbox(a_i);
  end

endmodule

// File: rtl/aes_key_scheduler.sv
// AES-128 key scheduler: expands a loaded key into 11 round keys (2 cycles per
// round) and serves them through a registered request/acknowledge port.
module aes_key_scheduler
  import aes_key_pkg::*;
#(
  parameter int NUM_ROUNDS = 10,
  parameter int KEY_W      = 128
) (
  input  logic               clk,
  input  logic               reset_n,
  aes_key_scheduler_if.slave bus
);

  if (NUM_ROUNDS != 10 || KEY_W != 128) begin : g_bad_param
    $error("aes_key_scheduler supports only AES-128 (NUM_ROUNDS=10, KEY_W=128)");
  end

  localparam logic [3:0] LAST_RND = 4'(NUM_ROUNDS);

  state_e       state_q, state_d;
  logic [3:0]   round_q, round_d;
  logic         ld_key, wr_rk;
  logic [127:0] prev_q;
  logic [127:0] rk_q [NUM_RK];
  logic [31:0]  rot_w, sub_w, rcon_w;
  logic [127:0] next_key;
  logic         keys_valid, idx_ok;
  logic         rk_ack_q, rk_err_q;
  logic [127:0] rk_data_q;

  // prev_q always holds rk[round-1], so the RotWord mux is a fixed wiring.
  assign rot_w = {prev_q[23:0], prev_q[31:24]};

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    sbox_sync u_sbox (
      .clk    (clk),
      .reset_n(reset_n),
      .a_i    (rot_w[8*b +: 8]),
      .q_o    (sub_w[8*b +: 8])
    );
  end

  assign rcon_w = rcon(round_q);

  key_round_step u_step (
    .prev_key_i(prev_q),
    .sub_word_i(sub_w),
    .rcon_i    (rcon_w),
    .next_key_o(next_key)
  );

  // Next-state logic: SUB waits for the S-box register, MIX commits the key.
  always_comb begin
    state_d = state_q;
    round_d = round_q;
    ld_key  = 1'b0;
    wr_rk   = 1'b0;
    case (state_q)
      IDLE, READY: begin
        if (bus.load) begin
          ld_key  = 1'b1;
          round_d = 4'd1;
          state_d = SUB;
        end
      end
      SUB: state_d = MIX;
      MIX: begin
        wr_rk = 1'b1;
        if (round_q == LAST_RND) begin
          state_d = READY;
        end else begin
          round_d = round_q + 4'd1;
          state_d = SUB;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and round counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      round_q <= 4'd0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
    end
  end

  // Key store; contents are gated by keys_valid so it needs no reset.
  always_ff @(posedge clk) begin
    if (ld_key) begin
      prev_q   <= bus.key;
      rk_q[0]  <= bus.key;
    end else if (wr_rk) begin
      prev_q        <= next_key;
      rk_q[round_q] <= next_key;
    end
  end

  assign keys_valid = (state_q == READY);
  assign idx_ok     = (bus.rk_idx < 4'(NUM_RK));

  // Read port: one registered response per request; a same-edge load still
  // sees the old store because the store write is non-blocking.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rk_ack_q  <= 1'b0;
      rk_err_q  <= 1'b0;
      rk_data_q <= '0;
    end else begin
      rk_ack_q <= bus.rk_req;
      if (bus.rk_req && keys_valid && idx_ok) begin
        rk_data_q <= rk_q[bus.rk_idx];
        rk_err_q  <= 1'b0;
      end else if (bus.rk_req) begin
        rk_data_q <= '0;
        rk_err_q  <= 1'b1;
      end else begin
        rk_data_q <= '0;
        rk_err_q  <= 1'b0;
      end
    end
  end

  assign bus.busy       = (state_q == SUB) || (state_q == MIX);
  assign bus.keys_valid = keys_valid;
  assign bus.rk_ack     = rk_ack_q;
  assign bus.rk_err     = rk_err_q;
  assign bus.rk_data    = rk_data_q;

endmodule

// File: tb/tb_aes_key_scheduler.sv
// Self-checking bench for aes_key_scheduler against a word-level FIPS-197
// key expansion model.
module tb_aes_key_scheduler;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  aes_key_scheduler_if #(.KEY_W(128)) bus ();

  aes_key_scheduler #(.NUM_ROUNDS(10), .KEY_W(128)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [127:0] exp_rk [11];
  logic [127:0] old_rk [11];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Carry-less product then reduction by x^8+x^4+x^3+x+1.
  function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = 16'h0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [7:0] m_sbox(input logic [7:0] x);
    logic [7:0] inv, s, c;
    inv = 8'h00;
    c   = 8'h63;
    if (x != 8'h00)
      for (int b = 1; b < 256; b++) if (m_mul(x, 8'(b)) == 8'h01) inv = 8'(b);
    for (int j = 0; j < 8; j++)
      s[j] = inv[j] ^ inv[(j+4)%8] ^ inv[(j+5)%8] ^ inv[(j+6)%8] ^ inv[(j+7)%8] ^ c[j];
    return s;
  endfunction

  task automatic expand(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {m_sbox(t[31:24]), m_sbox(t[23:16]), m_sbox(t[15:8]), m_sbox(t[7:0])};
        t[31:24] = t[31:24] ^ rc;
        rc = m_mul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [127:0] k);
    bus.load = 1'b1;
    bus.key  = k;
    step();
    bus.load = 1'b0;
  endtask

  task automatic rd(input logic [3:0] idx, input logic [127:0] exp_d, input logic exp_err,
                    input string tag);
    bus.rk_req = 1'b1;
    bus.rk_idx = idx;
    step();
    bus.rk_req = 1'b0;
    chkb({tag, "_ack"}, bus.rk_ack, 1'b1);
    chkb({tag, "_err"}, bus.rk_err, exp_err);
    chk({tag, "_data"}, bus.rk_data, exp_d);
  endtask

  task automatic rd_all(input string tag);
    for (int i = 0; i < 11; i++) begin
      bus.rk_req = 1'b1;
      bus.rk_idx = 4'(i);
      step();
      chkb($sformatf("%s_ack%0d", tag, i), bus.rk_ack, 1'b1);
      chkb($sformatf("%s_err%0d", tag, i), bus.rk_err, 1'b0);
      chk($sformatf("%s_rk%0d", tag, i), bus.rk_data, exp_rk[i]);
    end
    bus.rk_req = 1'b0;
    step();
    chkb({tag, "_ack_idle"}, bus.rk_ack, 1'b0);
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!bus.keys_valid && n < 40) begin
      step();
      n++;
    end
  endtask

  function automatic logic [127:0] rnd_key();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // ---------------- directed sequence ----------------
  initial begin
    logic [127:0] k;
    int n, lows, kv_cnt;
    logic [3:0] idx;

    bus.load   = 1'b0;
    bus.key    = '0;
    bus.rk_req = 1'b0;
    bus.rk_idx = '0;
    reset_n    = 1'b0;
    step();
    step();
    chkb("rst_busy", bus.busy, 1'b0);
    chkb("rst_kv", bus.keys_valid, 1'b0);
    chkb("rst_ack", bus.rk_ack, 1'b0);
    chkb("rst_err", bus.rk_err, 1'b0);
    chk("rst_data", bus.rk_data, 128'h0);
    reset_n = 1'b1;
    step();

    // Read before any key exists.
    rd(4'd3, 128'h0, 1'b1, "prekey");

    // FIPS-197 appendix A.1 key.
    k = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    expand(k);
    chk("model_rk1", exp_rk[1], 128'ha0fafe1788542cb123a339392a6c7605);
    do_load(k);
    chkb("fips_busy0", bus.busy, 1'b1);
    chkb("fips_kv0", bus.keys_valid, 1'b0);
    lows = 0;
    for (int i = 1; i < 20; i++) begin
      step();
      if (bus.busy !== 1'b1 || bus.keys_valid !== 1'b0) lows++;
    end
    chki("fips_busy_hold", lows, 0);
    step();
    chkb("fips_busy_end", bus.busy, 1'b0);
    chkb("fips_kv_end", bus.keys_valid, 1'b1);
    rd(4'd1, 128'ha0fafe1788542cb123a339392a6c7605, 1'b0, "fips_rk1");
    rd(4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 1'b0, "fips_rk10");
    rd(4'd0, k, 1'b0, "fips_rk0");
    rd_all("fips_all");
    rd(4'd11, 128'h0, 1'b1, "idx11");
    rd(4'd15, 128'h0, 1'b1, "idx15");

    // Random key; read while busy and a second load mid-expansion (ignored).
    k = rnd_key();
    expand(k);
    do_load(k);
    rd(4'd3, 128'h0, 1'b1, "busy_rd");
    step();
    step();
    step();
    do_load(rnd_key());
    wait_ready(n);
    chki("ignored_load_lat", n, 15);
    rd_all("ign");

    // New load in READY with a same-edge read of idx 10.
    for (int i = 0; i < 11; i++) old_rk[i] = exp_rk[i];
    k = rnd_key();
    bus.load   = 1'b1;
    bus.key    = k;
    bus.rk_req = 1'b1;
    bus.rk_idx = 4'd10;
    step();
    bus.load   = 1'b0;
    bus.rk_req = 1'b0;
    chkb("same_edge_ack", bus.rk_ack, 1'b1);
    chkb("same_edge_err", bus.rk_err, 1'b0);
    chk("same_edge_data", bus.rk_data, old_rk[10]);
    chkb("same_edge_kv", bus.keys_valid, 1'b0);
    expand(k);
    wait_ready(n);
    chki("reload_lat", n, 20);
    rd_all("reload");
    for (int i = 0; i < 8; i++) begin
      idx = 4'($urandom_range(0, 15));
      rd(idx, (idx <= 4'd10) ? exp_rk[idx] : 128'h0, idx > 4'd10,
         $sformatf("rnd_rd%0d", i));
    end

    // Reset asserted during MIX of round 6.
    do_load(rnd_key());
    for (int i = 1; i < 11; i++) step();
    bus.rk_req = 1'b1;
    bus.rk_idx = 4'd2;
    step();
    bus.rk_req = 1'b0;
    chkb("mid_busy", bus.busy, 1'b1);
    chkb("mid_ack", bus.rk_ack, 1'b1);
    chkb("mid_err", bus.rk_err, 1'b1);
    reset_n = 1'b0;
    #1;
    chkb("arst_busy", bus.busy, 1'b0);
    chkb("arst_kv", bus.keys_valid, 1'b0);
    chkb("arst_ack", bus.rk_ack, 1'b0);
    chkb("arst_err", bus.rk_err, 1'b0);
    step();
    step();
    reset_n = 1'b1;
    kv_cnt = 0;
    for (int i = 0; i < 25; i++) begin
      step();
      if (bus.keys_valid !== 1'b0 || bus.busy !== 1'b0) kv_cnt++;
    end
    chki("post_rst_quiet", kv_cnt, 0);
    k = rnd_key();
    expand(k);
    do_load(k);
    wait_ready(n);
    chki("post_rst_lat", n, 20);
    rd_all("post_rst");

    // All-zero key.
    expand(128'h0);
    do_load(128'h0);
    wait_ready(n);
    chki("zero_lat", n, 20);
    rd(4'd1, 128'h62636363626363636263636362636363, 1'b0, "zero_rk1");
    rd(4'd10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e, 1'b0, "zero_rk10");
    rd(4'd0, 128'h0, 1'b0, "zero_rk0");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
